// File: rtl/layer0_feature_rx.sv
// Layer-0 feature stream receiver: stores 64-bit beats row by row in a circular
// line buffer and exposes complete rows through a registered random-access read port.
module layer0_feature_rx #(
   parameter int COL_NUM = 416,
   parameter int ROW_NUM = 4,
   parameter int ROW_W   = 2,
   parameter int COL_W   = 9
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic [63:0]      feature_data,
   input  logic             feature_valid,
   input  logic             feature_last,
   output logic             ready,
   input  logic             row_release,
   output logic [ROW_W:0]   rows_avail,
   input  logic [ROW_W-1:0] rd_row,
   input  logic [COL_W-1:0] rd_col,
   output logic [63:0]      rd_data,
   output logic             busy,
   output logic [7:0]       burst_cnt,
   output logic             last_err
);

   localparam int DEPTH  = ROW_NUM * COL_NUM;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COL_NUM - 1);
   localparam logic [ROW_W:0]    ROWS_FULL = (ROW_W + 1)'(ROW_NUM);
   localparam logic [ADDR_W-1:0] ROW_SPAN  = ADDR_W'(COL_NUM);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t            state;
   state_t            state_next;
   logic [COL_W-1:0]  col_cnt;
   logic [COL_W-1:0]  col_cnt_next;
   logic [ROW_W-1:0]  wr_slot;
   logic [ROW_W-1:0]  rd_slot;
   logic [ROW_W:0]    rows_avail_next;
   logic              accept;
   logic              at_row_end;
   logic              row_done;
   logic              good_last;
   logic              bad_last;
   logic              release_ok;
   logic [ROW_W-1:0]  rd_phys;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [63:0]       mem [DEPTH];

   // Handshake: a beat transfers on a rising clock edge where feature_valid and
   // ready are both high; the sender must hold data/last stable until then.
   assign accept     = feature_valid & ready;
   assign at_row_end = (col_cnt == COL_LAST);
   assign row_done   = accept & at_row_end;
   assign good_last  = accept & feature_last & at_row_end;
   assign bad_last   = accept & feature_last & ~at_row_end;
   assign release_ok = row_release & (rows_avail != '0);

   always_comb begin
      rows_avail_next = rows_avail;
      case ({row_done, release_ok})
         2'b10:   rows_avail_next = rows_avail + 1'b1;
         2'b01:   rows_avail_next = rows_avail - 1'b1;
         default: rows_avail_next = rows_avail;
      endcase
   end

   // A last off the row boundary throws the partial row away.
   always_comb begin
      col_cnt_next = col_cnt;
      if (accept) begin
         if (at_row_end || feature_last) begin
            col_cnt_next = '0;
         end else begin
            col_cnt_next = col_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         ready      <= 1'b0;
         rows_avail <= '0;
         col_cnt    <= '0;
         wr_slot    <= '0;
         rd_slot    <= '0;
         burst_cnt  <= '0;
         last_err   <= 1'b0;
      end else begin
         ready      <= (rows_avail_next < ROWS_FULL);
         rows_avail <= rows_avail_next;
         col_cnt    <= col_cnt_next;
         if (row_done) begin
            wr_slot <= wr_slot + 1'b1;
         end
         if (release_ok) begin
            rd_slot <= rd_slot + 1'b1;
         end
         if (good_last) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
         if (bad_last) begin
            last_err <= 1'b1;
         end
      end
   end

   // Burst-tracking FSM: state register, next-state logic, output decode.
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && !feature_last) state_next = RECV;
         RECV:    if (accept && feature_last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RECV);
   end

   assign rd_phys = rd_slot + rd_row;
   assign wr_addr = ADDR_W'(wr_slot) * ROW_SPAN + ADDR_W'(col_cnt);
   assign rd_addr = ADDR_W'(rd_phys) * ROW_SPAN + ADDR_W'(rd_col);

   always_ff @(posedge sclk) begin
      if (accept) begin
         mem[wr_addr] <= feature_data;
      end
   end

   // Non-blocking read of the array gives read-before-write on a shared address.
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         rd_data <= '0;
      end else if ({1'b0, rd_addr} < DEPTH_EXT) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_layer0_feature_rx.sv
// Bench for layer0_feature_rx: random streams against a row-queue reference model,
// read data checked through an expected-value queue by a separate monitor.
module tb_layer0_feature_rx;

   localparam int COL_NUM = 416;
   localparam int ROW_NUM = 4;
   localparam int ROW_W   = 2;
   localparam int COL_W   = 9;

   typedef logic [63:0] row_t [COL_NUM];

   logic             sclk = 1'b0;
   logic             s_rst = 1'b1;
   logic [63:0]      feature_data = '0;
   logic             feature_valid = 1'b0;
   logic             feature_last = 1'b0;
   logic             ready;
   logic             row_release = 1'b0;
   logic [ROW_W:0]   rows_avail;
   logic [ROW_W-1:0] rd_row = '0;
   logic [COL_W-1:0] rd_col = '0;
   logic [63:0]      rd_data;
   logic             busy;
   logic [7:0]       burst_cnt;
   logic             last_err;

   layer0_feature_rx #(
      .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .ROW_W(ROW_W), .COL_W(COL_W)
   ) dut (
      .sclk(sclk), .s_rst(s_rst), .feature_data(feature_data),
      .feature_valid(feature_valid), .feature_last(feature_last), .ready(ready),
      .row_release(row_release), .rows_avail(rows_avail), .rd_row(rd_row),
      .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .burst_cnt(burst_cnt),
      .last_err(last_err)
   );

   always #5 sclk = ~sclk;

   int          n_pass = 0;
   int          n_total = 0;
   int          gcyc = 0;
   logic [63:0] exp_q [$];
   logic        rd_req = 1'b0;
   logic        rd_req_d = 1'b0;

   // Reference model: a FIFO of complete rows plus the partial row being filled.
   row_t        rows_q [$];
   row_t        part;
   int          part_len = 0;
   logic        m_busy = 1'b0;
   logic [7:0]  m_burst = '0;
   logic        m_err = 1'b0;
   bit          row_pushed = 0;
   int          rel_due [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   always @(posedge sclk) rd_req_d <= rd_req;

   initial begin
      forever begin
         @(negedge sclk);
         if (rd_req_d) begin
            if (exp_q.size() == 0) begin
               chk("rd_queue_underflow", 64'd1, 64'd0);
            end else begin
               chk("rd_data", rd_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_status();
      chk("ready", 64'(ready), 64'(rows_q.size() < ROW_NUM));
      chk("rows_avail", 64'(rows_avail), 64'(rows_q.size()));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("burst_cnt", 64'(burst_cnt), 64'(m_burst));
      chk("last_err", 64'(last_err), 64'(m_err));
   endtask

   task automatic model_step(input logic acc, input logic [63:0] d, input logic l, input logic rel);
      row_pushed = 0;
      if (rel && rows_q.size() > 0) void'(rows_q.pop_front());
      if (acc) begin
         part[part_len] = d;
         if (part_len == COL_NUM - 1) begin
            rows_q.push_back(part);
            part_len = 0;
            row_pushed = 1;
            if (l) m_burst = m_burst + 8'd1;
         end else if (l) begin
            m_err = 1'b1;
            part_len = 0;
         end else begin
            part_len++;
         end
         m_busy = !l;
      end
   endtask

   // Entered and left at #1 after a rising edge.
   task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic rel,
                        input logic rd_en, input int rr, input int rc, output logic acc);
      feature_valid = v;
      feature_data  = d;
      feature_last  = l;
      row_release   = rel;
      rd_row        = ROW_W'(rr);
      rd_col        = COL_W'(rc);
      if (rd_en && rr < rows_q.size()) begin
         exp_q.push_back(rows_q[rr][rc]);
         rd_req = 1'b1;
      end else begin
         rd_req = 1'b0;
      end
      @(negedge sclk);
      check_status();
      acc = v && (rows_q.size() < ROW_NUM);
      @(posedge sclk);
      #1;
      model_step(acc, d, l, rel);
      gcyc++;
   endtask

   task automatic settle();
      feature_valid = 1'b0;
      feature_last  = 1'b0;
      row_release   = 1'b0;
      rd_req        = 1'b0;
      @(negedge sclk);
   endtask

   task automatic resume();
      @(posedge sclk);
      #1;
      gcyc++;
   endtask

   task automatic do_reset();
      settle();
      @(posedge sclk);
      #1;
      s_rst = 1'b1;
      @(negedge sclk);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_rows_avail", 64'(rows_avail), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
      chk("rst_last_err", 64'(last_err), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      rows_q.delete();
      rel_due.delete();
      part_len = 0;
      m_busy = 1'b0;
      m_burst = '0;
      m_err = 1'b0;
      @(posedge sclk);
      #1;
      s_rst = 1'b0;
      @(posedge sclk);
      #1;
   endtask

   task automatic run(input int n, input int last_idx, input bit auto_rel, input bit hold,
                      input bit pat, input int row_base, input int max_cyc, output int accepted);
      logic [63:0] cur_d;
      logic        v, l, rel, a, rd_en;
      int          rr, rc;
      accepted = 0;
      cur_d = pat ? {32'(row_base), 32'd0} : {$urandom, $urandom};
      for (int c = 0; c < max_cyc; c++) begin
         if (accepted >= n && rel_due.size() == 0) break;
         v = (accepted < n) && (hold || $urandom_range(0, 3) != 0);
         l = v && (accepted == last_idx);
         rel = 1'b0;
         if (auto_rel && rel_due.size() > 0 && rel_due[0] <= gcyc) begin
            rel = 1'b1;
            void'(rel_due.pop_front());
         end
         rd_en = 1'($urandom_range(0, 1));
         rr = $urandom_range(0, ROW_NUM - 1);
         rc = $urandom_range(0, COL_NUM - 1);
         cycle(v, cur_d, l, rel, rd_en, rr, rc, a);
         if (a) begin
            accepted++;
            cur_d = pat ? {32'(row_base + accepted / COL_NUM), 32'(accepted % COL_NUM)}
                        : {$urandom, $urandom};
         end
         if (auto_rel && row_pushed) rel_due.push_back(gcyc + 10);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc;
      logic a;

      // 1: full image with paced releases
      do_reset();
      run(9 * COL_NUM, 9 * COL_NUM - 1, 1, 0, 0, 0, 8000, acc);
      chk("t1_accepted", 64'(acc), 64'(9 * COL_NUM));
      settle();
      chk("t1_burst_cnt", 64'(burst_cnt), 64'd1);
      chk("t1_last_err", 64'(last_err), 64'd0);
      chk("t1_busy", 64'(busy), 64'd0);
      resume();

      // 2: back-pressure without releases
      do_reset();
      run(9 * COL_NUM, -1, 0, 1, 0, 0, 3000, acc);
      chk("t2_accepted", 64'(acc), 64'(ROW_NUM * COL_NUM));
      settle();
      chk("t2_rows_full", 64'(rows_avail), 64'(ROW_NUM));
      chk("t2_ready_low", 64'(ready), 64'd0);
      resume();
      cycle(1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 0, 0, a);
      settle();
      chk("t2_rows_after_rel", 64'(rows_avail), 64'd3);
      chk("t2_ready_back", 64'(ready), 64'd1);
      resume();
      run(10, -1, 0, 1, 0, 0, 100, acc);
      chk("t2_resume", 64'(acc), 64'd10);

      // 3: pattern rows, release one, directed reads
      do_reset();
      run(4 * COL_NUM, 4 * COL_NUM - 1, 0, 0, 1, 0, 4000, acc);
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 0, 0, a);
      cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 0, 5, a);
      settle();
      chk("t3_rd_0_5", rd_data, {32'd1, 32'd5});
      resume();
      cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 2, 415, a);
      settle();
      chk("t3_rd_2_415", rd_data, {32'd3, 32'd415});
      resume();

      // 4: last off the row boundary
      do_reset();
      run(100, 99, 0, 0, 0, 0, 400, acc);
      settle();
      chk("t4_last_err", 64'(last_err), 64'd1);
      chk("t4_rows", 64'(rows_avail), 64'd0);
      chk("t4_burst", 64'(burst_cnt), 64'd0);
      resume();
      run(COL_NUM, COL_NUM - 1, 0, 0, 1, 'h55, 1000, acc);
      cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 0, 0, a);
      settle();
      chk("t4_col0", rd_data, {32'h55, 32'd0});
      resume();

      // 5: completion and release in the same cycle, release when empty
      do_reset();
      run(2 * COL_NUM + COL_NUM - 1, -1, 0, 0, 0, 0, 3000, acc);
      cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 0, 0, a);
      settle();
      chk("t5_rows_same", 64'(rows_avail), 64'd2);
      resume();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, i % 2, $urandom_range(0, COL_NUM - 1), a);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 0, 0, a);
      end
      settle();
      chk("t5_rows_empty", 64'(rows_avail), 64'd0);
      resume();

      // 6: reset in the middle of row 1
      do_reset();
      run(COL_NUM + 200, -1, 0, 0, 0, 0, 2000, acc);
      do_reset();
      run(COL_NUM, COL_NUM - 1, 0, 0, 1, 'h20, 1000, acc);
      cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 0, 0, a);
      settle();
      chk("t6_row0_col0", rd_data, {32'h20, 32'd0});
      chk("t6_rows", 64'(rows_avail), 64'd1);
      resume();

      // 7: random bursts, some ending off a row boundary
      do_reset();
      for (int i = 0; i < 4; i++) begin
         int n;
         n = $urandom_range(1, 1000);
         run(n, n - 1, 1, 0, 0, 0, 4000, acc);
         chk("t7_accepted", 64'(acc), 64'(n));
      end

      settle();
      repeat (3) @(negedge sclk);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/layer0_feature_rx.md
Name: layer0_feature_rx

Overview:
Receive side of the layer-0 feature stream. Accepts 64-bit beats (8 channels x 8 bit per pixel) over a valid/ready/last handshake and stores them row by row into a circular on-chip line buffer of ROW_NUM rows of COL_NUM beats. The downstream convolution engine reads stored rows through a random-access read port. It frees each row with a release pulse, and that release drives back-pressure to the sender.

Parameters:
COL_NUM, 416, beats per image row (pixels per row).
ROW_NUM, 4, rows held in the line buffer; must be a power of two.
ROW_W, 2, log2(ROW_NUM).
COL_W, 9, width of column index; 2^COL_W >= COL_NUM.

Ports:
sclk  in  1  system clock, all logic on rising edge.
s_rst  in  1  asynchronous, active-high reset.
feature_data  in  64  beat payload.
feature_valid  in  1  beat valid.
feature_last  in  1  final beat of a burst; qualified by feature_valid.
ready  out  1  receiver can accept a beat this cycle.
row_release  in  1  one-cycle pulse; frees the oldest stored row.
rows_avail  out  ROW_W+1  number of complete rows held, 0..ROW_NUM.
rd_row  in  ROW_W  row offset from the oldest stored row (0 = oldest).
rd_col  in  COL_W  column index to read.
rd_data  out  64  read data.
busy  out  1  a burst is in progress.
burst_cnt  out  8  bursts completed correctly, wraps 255->0.
last_err  out  1  sticky flag: feature_last arrived off a row boundary.

Behaviour:
- Reset values while s_rst=1: ready=0, rows_avail=0, rd_data=0, busy=0, burst_cnt=0, last_err=0. Internal wr_slot, rd_slot and col_cnt are also 0. RAM contents are not cleared.
- ready is a register. First cycle after reset release: ready=1. Each cycle, next value = (rows_avail_next < ROW_NUM).
- Accept: a beat is accepted when feature_valid && ready. Write address = wr_slot*COL_NUM + col_cnt, written the same cycle.
- col_cnt: increments on each accepted beat. On an accepted beat with col_cnt==COL_NUM-1, col_cnt returns to 0, the row is complete, wr_slot advances mod ROW_NUM, and rows_avail increments.
- row_release: rd_slot advances mod ROW_NUM and rows_avail decrements. A release with rows_avail==0 is ignored.
- Row complete and release in the same cycle: rows_avail is unchanged and both pointers advance.
- Full: when rows_avail reaches ROW_NUM, ready is 0 on the following cycle. Beats presented while ready=0 are not accepted. Upstream holds the data.
- Read: physical slot = (rd_slot + rd_row) mod ROW_NUM. rd_data is registered with exactly 1-cycle latency from rd_row/rd_col.
  - Reading a slot that is currently being written returns the RAM's old data (read-before-write).
  - Reads with rd_row >= rows_avail return undefined data and must not disturb state.
- FSM with two states:
  - IDLE to RECV on the first accepted beat without last.
  - RECV to IDLE on an accepted beat with feature_last.
  - A single-beat burst (last on the first beat) stays in IDLE.
  - busy = (state==RECV).
- feature_last checking:
  - Accepted last with col_cnt==COL_NUM-1: burst_cnt increments.
  - Accepted last with any other col_cnt: last_err=1 (sticky until reset), the partial row is discarded (col_cnt=0, wr_slot unchanged, rows_avail unchanged), and burst_cnt is not incremented.
- Reset mid-burst: all counters, pointers and the FSM return to reset values immediately. The partial row is lost.
- Arithmetic: rows_avail is ROW_W+1 bits and never exceeds ROW_NUM. Pointers wrap by natural ROW_W-bit overflow.

Test Plan:
1. Reset, then stream 9*416 beats with last on beat 3743; consumer releases each row 10 cycles after rows_avail rises -> all beats accepted, burst_cnt=1, last_err=0, busy falls the cycle after the last beat.
2. No releases; stream 9*416 beats with valid held high -> exactly 1664 beats accepted, rows_avail=4, ready=0. One row_release pulse -> rows_avail=3, ready=1 the following cycle, and acceptance resumes.
3. Write 4 rows with data = {row,col}, release 1 row, then rd_row=0, rd_col=5 -> rd_data = {1,5} one cycle later. rd_row=2, rd_col=415 -> {3,415}.
4. Burst with feature_last on accepted beat 100 (col_cnt=99) -> last_err=1, rows_avail unchanged, burst_cnt unchanged. The next beat is written to column 0 of the same slot.
5. rows_avail=2; row completes in the same cycle as row_release -> rows_avail stays 2 and rd_slot advances by 1. row_release with rows_avail=0 -> no change.
6. Assert s_rst at col_cnt=200 of row 1 -> ready=0, rows_avail=0, busy=0 while in reset. After release, ready=1 and the next beat is written to slot 0, column 0.
